// File: rtl/axi4_slave_write_burst_engine.sv
// AXI4 slave write burst engine: accepts one AW burst, consumes its W beats,
// drives a byte-strobed memory write port (1-cycle latency) and returns B.
// Optional: define AXI4_WR_4KB_BOUNDARY_CHECK_EN to reject INCR bursts that
// cross a 4 KB page (SLVERR, no memory writes, beats still consumed).
module axi4_slave_write_burst_engine #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 64,
  parameter int                       ID_WIDTH      = 4,
  parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS   = 'h0000_0000,
  parameter logic [ADDRESS_WIDTH-1:0] MAX_ADDRESS   = 'h0000_2FFF
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [ID_WIDTH-1:0]        awid,
  input  logic [ADDRESS_WIDTH-1:0]   awaddr,
  input  logic [7:0]                 awlen,
  input  logic [2:0]                 awsize,
  input  logic [1:0]                 awburst,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic [DATA_WIDTH/8-1:0]    wstrb,
  input  logic                       wlast,
  input  logic                       wvalid,
  output logic                       wready,
  output logic [ID_WIDTH-1:0]        bid,
  output logic [1:0]                 bresp,
  output logic                       bvalid,
  input  logic                       bready,
  output logic                       mem_we,
  output logic [ADDRESS_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  output logic [DATA_WIDTH/8-1:0]    mem_wstrb
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int SZW    = $clog2(STRB_W);
  localparam logic [ADDRESS_WIDTH-1:0] ONE = 1;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RSVD  = 2'd3;
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_e;
  state_e state_q, state_d;

  logic [ID_WIDTH-1:0]      id_q;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d, s_q, mask_q;
  logic [1:0]               burst_q, resp_q;
  logic [7:0]               len_q, cnt_q;
  logic                     sup_q;
  logic                     mem_we_q;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0]    mem_wdata_q;
  logic [STRB_W-1:0]        mem_wstrb_q;

  logic aw_hs, w_hs, last_beat;
  assign aw_hs     = awvalid && (state_q == S_IDLE);
  assign w_hs      = wvalid && (state_q == S_DATA);
  assign last_beat = (cnt_q == len_q);

  // AW decode: beat size, aligned start, wrap window, final beat address, response class
  logic [ADDRESS_WIDTH-1:0] aw_s, aw_a, aw_span, aw_mask, aw_last;
  logic                     wrap_ok, aw_slv, aw_dec;
  logic [1:0]               aw_resp;
  always_comb begin
    aw_s    = ONE << awsize;
    aw_a    = awaddr & ~(aw_s - ONE);
    aw_span = ADDRESS_WIDTH'(awlen) * aw_s;
    aw_mask = (ADDRESS_WIDTH'(awlen) + ONE) * aw_s - ONE;
    wrap_ok = (awlen == 8'd1) || (awlen == 8'd3) || (awlen == 8'd7) || (awlen == 8'd15);
    if (awburst == BURST_FIXED)
      aw_last = aw_a;
    else if (awburst == BURST_WRAP && wrap_ok)
      aw_last = (aw_a & ~aw_mask) | ((aw_a + aw_span) & aw_mask);
    else
      aw_last = aw_a + aw_span;
    aw_slv = (awburst == BURST_RSVD) || (awburst == BURST_WRAP && !wrap_ok) ||
             (32'(awsize) > SZW);
`ifdef AXI4_WR_4KB_BOUNDARY_CHECK_EN
    if (awburst == 2'd1 && aw_a[ADDRESS_WIDTH-1:12] != aw_last[ADDRESS_WIDTH-1:12])
      aw_slv = 1'b1;
`endif
    // unsigned offset compare keeps the range check free of constant-zero tests
    aw_dec  = ((awaddr - MIN_ADDRESS) > (MAX_ADDRESS - MIN_ADDRESS)) ||
              ((aw_last - MIN_ADDRESS) > (MAX_ADDRESS - MIN_ADDRESS));
    aw_resp = aw_dec ? RESP_DECERR : (aw_slv ? RESP_SLVERR : RESP_OKAY);
  end

  // Next beat address: FIXED holds, WRAP folds back inside the window, INCR steps
  always_comb begin
    addr_d = addr_q;
    case (burst_q)
      BURST_FIXED: addr_d = addr_q;
      BURST_WRAP:  addr_d = (addr_q & ~mask_q) | ((addr_q + s_q) & mask_q);
      default:     addr_d = addr_q + s_q;
    endcase
  end

  // FSM state register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_d = state_q;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        awready = 1'b1;
        if (awvalid) state_d = S_DATA;
      end
      S_DATA: begin
        wready = 1'b1;
        if (wvalid && last_beat) state_d = S_RESP;
      end
      S_RESP: begin
        bvalid = 1'b1;
        if (bready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Burst context: latched at AW, beat address/count advance per accepted beat
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      id_q    <= '0;
      addr_q  <= '0;
      s_q     <= '0;
      mask_q  <= '0;
      burst_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      sup_q   <= 1'b0;
      resp_q  <= RESP_OKAY;
    end else if (aw_hs) begin
      id_q    <= awid;
      addr_q  <= aw_a;
      s_q     <= aw_s;
      mask_q  <= aw_mask;
      burst_q <= awburst;
      len_q   <= awlen;
      cnt_q   <= '0;
      sup_q   <= (aw_resp != RESP_OKAY);
      resp_q  <= aw_resp;
    end else if (w_hs) begin
      addr_q <= addr_d;
      cnt_q  <= cnt_q + 8'd1;
      // a misplaced wlast downgrades an otherwise clean burst; writes continue
      if ((wlast != last_beat) && resp_q == RESP_OKAY) resp_q <= RESP_SLVERR;
    end
  end

  // Memory write port: one registered pulse per beat of an error-free burst
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      if (w_hs && !sup_q) begin
        mem_we_q    <= 1'b1;
        mem_addr_q  <= addr_q;
        mem_wdata_q <= wdata;
        mem_wstrb_q <= wstrb;
      end
    end
  end

  assign bid       = id_q;
  assign bresp     = resp_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_axi4_slave_write_burst_engine.sv
// Self-checking bench for axi4_slave_write_burst_engine: directed table,
// multi-cycle corner sequences and randomized bursts vs. a reference model.
module tb_axi4_slave_write_burst_engine;

  localparam logic [31:0] MAXA = 32'h0000_2FFF;

  logic        aclk, areset;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;

  axi4_slave_write_burst_engine dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  typedef struct packed {logic [31:0] a; logic [63:0] d; logic [7:0] s;} wr_t;
  wr_t mon_q[$];

  // capture every memory write pulse
  always @(negedge aclk) if (mem_we) mon_q.push_back('{mem_addr, mem_wdata, mem_wstrb});

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // reference: beat n byte address from the burst rules
  function automatic logic [31:0] m_addr(input logic [31:0] addr, input int len, input int size,
                                         input int burst, input int n);
    longint unsigned S, A, L, lower;
    S = 64'd1 << size;
    A = (64'(addr) / S) * S;
    if (burst == 0) return A[31:0];
    if (burst == 2 && (len inside {1, 3, 7, 15})) begin
      L     = S * longint'(len + 1);
      lower = (64'(addr) / L) * L;
      return 32'(lower + (A - lower + longint'(n) * S) % L);
    end
    return 32'(A + longint'(n) * S);
  endfunction

  // reference: response class decided at AW time
  function automatic logic [1:0] m_aw_resp(input logic [31:0] addr, input int len, input int size,
                                           input int burst);
    logic [31:0] first, last;
    logic slv, dec;
    first = m_addr(addr, len, size, burst, 0);
    last  = m_addr(addr, len, size, burst, len);
    slv   = (burst == 3) || (burst == 2 && !(len inside {1, 3, 7, 15})) || (size > 3);
`ifdef AXI4_WR_4KB_BOUNDARY_CHECK_EN
    if (burst == 1 && first[31:12] != last[31:12]) slv = 1'b1;
`endif
    dec = (addr > MAXA) || (last > MAXA);
    return dec ? 2'd3 : (slv ? 2'd2 : 2'd0);
  endfunction

  // drive one full burst and check response, id and every memory write
  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input int bad, input int bstall,
                           output logic [1:0] got_resp, output int got_nw);
    logic [1:0]  aw_r, exp_r;
    logic [63:0] dq[$];
    logic [7:0]  sq[$];
    int t, exp_nw;
    aw_r   = m_aw_resp(addr, len, size, burst);
    exp_r  = (aw_r != 2'd0) ? aw_r : ((bad >= 0) ? 2'd2 : 2'd0);
    exp_nw = (aw_r != 2'd0) ? 0 : len + 1;
    got_resp = 2'bxx;
    got_nw   = 0;
    mon_q.delete();
    @(negedge aclk);
    awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
    awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin @(negedge aclk); t++; end
    if (!awready) begin chk("awready_wait", awready, 1'b1); awvalid = 1'b0; return; end
    @(negedge aclk);
    awvalid = 1'b0;
    for (int n = 0; n <= len; n++) begin
      if ($urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(negedge aclk); end
      wdata  = {$urandom, $urandom};
      wstrb  = 8'($urandom);
      wlast  = (n == bad) ? (n != len) : (n == len);
      wvalid = 1'b1;
      t = 0;
      while (!wready && t < 50) begin @(negedge aclk); t++; end
      if (!wready) begin chk("wready_wait", wready, 1'b1); wvalid = 1'b0; return; end
      dq.push_back(wdata);
      sq.push_back(wstrb);
      @(negedge aclk);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    t = 0;
    while (!bvalid && t < 50) begin @(negedge aclk); t++; end
    if (!bvalid) begin chk("bvalid_wait", bvalid, 1'b1); return; end
    got_resp = bresp;
    for (int k = 0; k < bstall; k++) begin
      chk("stall_bvalid", bvalid, 1'b1);
      chk("stall_bresp", bresp, got_resp);
      chk("stall_awready", awready, 1'b0);
      @(negedge aclk);
    end
    chk("bid", bid, id);
    chk("bresp", bresp, exp_r);
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    chk("post_b_bvalid", bvalid, 1'b0);
    chk("post_b_awready", awready, 1'b1);
    got_nw = mon_q.size();
    chk("nwrites", got_nw, exp_nw);
    for (int i = 0; i < got_nw && i < exp_nw; i++) begin
      chk("wr_addr", mon_q[i].a, m_addr(addr, len, size, burst, i));
      chk("wr_data", mon_q[i].d, dq[i]);
      chk("wr_strb", mon_q[i].s, sq[i]);
    end
  endtask

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    int          len, size, burst, bad, stall;
    logic [1:0]  resp;
    int          nw;
    logic [31:0] a[4];
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [1:0] r;
    int nw, len, size, burst, bad;
    logic [31:0] addr;

    tbl[0]  = '{4'd3, 32'h100,  3, 3, 1, -1, 0, 2'd0, 4, '{32'h100, 32'h108, 32'h110, 32'h118}};
    tbl[1]  = '{4'd1, 32'h01C,  3, 2, 2, -1, 0, 2'd0, 4, '{32'h01C, 32'h010, 32'h014, 32'h018}};
    tbl[2]  = '{4'd2, 32'h204,  2, 2, 0, -1, 1, 2'd0, 3, '{32'h204, 32'h204, 32'h204, 32'h0}};
    tbl[3]  = '{4'd4, 32'h3000, 1, 3, 1, -1, 0, 2'd3, 0, '{32'h0, 32'h0, 32'h0, 32'h0}};
    tbl[4]  = '{4'd6, 32'h100,  1, 3, 3, -1, 0, 2'd2, 0, '{32'h0, 32'h0, 32'h0, 32'h0}};
    tbl[5]  = '{4'd7, 32'h100,  2, 2, 2, -1, 0, 2'd2, 0, '{32'h0, 32'h0, 32'h0, 32'h0}};
    tbl[6]  = '{4'd8, 32'h100,  1, 4, 1, -1, 0, 2'd2, 0, '{32'h0, 32'h0, 32'h0, 32'h0}};
    tbl[7]  = '{4'd9, 32'h2FF8, 1, 3, 1, -1, 0, 2'd3, 0, '{32'h0, 32'h0, 32'h0, 32'h0}};
    tbl[8]  = '{4'hA, 32'h800,  3, 3, 1,  1, 5, 2'd2, 4, '{32'h800, 32'h808, 32'h810, 32'h818}};
    tbl[9]  = '{4'hB, 32'h900,  1, 3, 1,  1, 0, 2'd2, 2, '{32'h900, 32'h908, 32'h0, 32'h0}};
`ifdef AXI4_WR_4KB_BOUNDARY_CHECK_EN
    tbl[10] = '{4'hC, 32'hFF8,  1, 3, 1, -1, 0, 2'd2, 0, '{32'h0, 32'h0, 32'h0, 32'h0}};
`else
    tbl[10] = '{4'hC, 32'hFF8,  1, 3, 1, -1, 0, 2'd0, 2, '{32'hFF8, 32'h1000, 32'h0, 32'h0}};
`endif

    areset = 1'b1; awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    awvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) @(negedge aclk);
    chk("rst_awready", awready, 1'b1);
    chk("rst_wready", wready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_bid", bid, 4'd0);
    chk("rst_bresp", bresp, 2'd0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_mem_wstrb", mem_wstrb, 8'd0);
    areset = 1'b0;

    // W without a preceding AW is ignored
    mon_q.delete();
    wvalid = 1'b1; wdata = 64'hDEAD; wstrb = 8'hFF; wlast = 1'b1;
    repeat (2) begin @(negedge aclk); chk("w_before_aw_wready", wready, 1'b0); end
    wvalid = 1'b0; wlast = 1'b0;
    @(negedge aclk);
    chk("w_before_aw_nowrite", mon_q.size(), 0);

    // directed table
    for (int i = 0; i < 11; i++) begin
      run_burst(tbl[i].id, tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst,
                tbl[i].bad, tbl[i].stall, r, nw);
      chk($sformatf("tbl%0d_resp", i), r, tbl[i].resp);
      chk($sformatf("tbl%0d_nw", i), nw, tbl[i].nw);
      for (int j = 0; j < nw && j < tbl[i].nw && j < 4; j++)
        chk($sformatf("tbl%0d_addr%0d", i, j), mon_q[j].a, tbl[i].a[j]);
    end

    // reset in the middle of a 4-beat INCR burst
    @(negedge aclk);
    awid = 4'd2; awaddr = 32'h100; awlen = 8'd3; awsize = 3'd3; awburst = 2'd1; awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    for (int n = 0; n < 2; n++) begin
      wdata = {$urandom, $urandom}; wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
      @(negedge aclk);
    end
    wdata = 64'h1234; wvalid = 1'b1;
    #2 areset = 1'b1;
    #1;
    chk("midrst_awready", awready, 1'b1);
    chk("midrst_wready", wready, 1'b0);
    chk("midrst_bvalid", bvalid, 1'b0);
    chk("midrst_mem_we", mem_we, 1'b0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    wvalid = 1'b0;
    mon_q.delete();
    @(negedge aclk);
    areset = 1'b0;
    repeat (4) @(negedge aclk);
    chk("midrst_no_writes", mon_q.size(), 0);
    chk("midrst_no_b", bvalid, 1'b0);
    run_burst(4'd5, 32'h40, 0, 3, 1, -1, 0, r, nw);
    chk("post_rst_resp", r, 2'd0);
    chk("post_rst_nw", nw, 1);

    // randomized bursts against the reference model
    for (int it = 0; it < 40; it++) begin
      burst = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      size  = ($urandom_range(0, 9) == 0) ? 4 : int'($urandom_range(0, 3));
      if (burst == 2 && $urandom_range(0, 4) != 0)
        len = (2 << $urandom_range(0, 3)) - 1;
      else
        len = $urandom_range(0, 15);
      addr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 'h3100));
      bad  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len)) : -1;
      run_burst(4'($urandom), addr, len, size, burst, bad, $urandom_range(0, 2), r, nw);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/axi4_slave_write_burst_engine.md
Name: axi4_slave_write_burst_engine

Overview:
- Slave-side write path that consumes one AXI4 write burst at a time (AW, W) and returns a B response.
- Expands AWADDR/AWLEN/AWSIZE/AWBURST into per-beat byte addresses and drives a byte-strobed memory write port.
- Sits between the slave interface pins and the slave memory model. Encodings match axi4_globals_pkg: burst FIXED/INCR/WRAP/RESERVED = 0/1/2/3, bresp OKAY/EXOKAY/SLVERR/DECERR = 0/1/2/3.

Parameters:
- ADDRESS_WIDTH, 32, AW address and memory address width.
- DATA_WIDTH, 64, W data width; power of 2, 8..1024.
- ID_WIDTH, 4, AWID/BID width.
- MIN_ADDRESS, 32'h0000_0000, lowest decoded byte address.
- MAX_ADDRESS, 32'h0000_2FFF, highest decoded byte address (12 KB).

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous, active-high reset
- awid  in  ID_WIDTH  write address ID
- awaddr  in  ADDRESS_WIDTH  start byte address
- awlen  in  8  beats minus 1
- awsize  in  3  log2 bytes per beat
- awburst  in  2  burst type
- awvalid  in  1  AW valid
- awready  out  1  AW ready
- wdata  in  DATA_WIDTH  write data
- wstrb  in  DATA_WIDTH/8  byte strobes
- wlast  in  1  last beat
- wvalid  in  1  W valid
- wready  out  1  W ready
- bid  out  ID_WIDTH  response ID
- bresp  out  2  write response
- bvalid  out  1  B valid
- bready  in  1  B ready
- mem_we  out  1  memory write enable, one cycle per accepted beat
- mem_addr  out  ADDRESS_WIDTH  beat byte address, aligned to awsize
- mem_wdata  out  DATA_WIDTH  registered wdata
- mem_wstrb  out  DATA_WIDTH/8  registered wstrb

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; awready=1, wready=0, bvalid=0, bid=0, bresp=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
- Reset mid-burst aborts the burst. No B is issued and no further mem_we pulses occur.
- FSM states: IDLE, DATA, RESP.
- IDLE: awready=1. On awvalid&&awready, latch id, addr, len, size, burst; clear beat count and error flag; go to DATA. Next cycle awready=0, wready=1.
- DATA: wready=1. Each wvalid&&wready is one beat, accepted at most once per cycle.
  - If the burst is error-free, mem_we=1 the following cycle with mem_addr = current beat address and wdata/wstrb registered (1-cycle latency).
  - The beat with count==len ends the burst and moves to RESP; wready=0 the next cycle.
- W-before-AW is not supported: wready stays 0 in IDLE.
- Beat addresses, with S=1<<size and A=addr aligned down to S:
  - FIXED: every beat at A.
  - INCR: beat n at A+n*S, modulo 2^ADDRESS_WIDTH.
  - WRAP: total L=S*(len+1); lower=floor(addr/L)*L; the address increments by S and returns to lower when it reaches lower+L.
- Error checks are evaluated at AW acceptance. Any error sets SLVERR, suppresses all mem_we for the burst, but all len+1 beats are still consumed:
  - awburst==3
  - WRAP with len not in {1,3,7,15}
  - S > DATA_WIDTH/8
- Decode check: start address or final beat address outside [MIN_ADDRESS, MAX_ADDRESS] gives DECERR. DECERR takes priority over SLVERR.
- wlast check: wlast must equal (count==len). On mismatch, bresp=SLVERR; writes already issued stand. On the last beat the burst ends on count, not on wlast.
- RESP: bvalid=1, bid=latched id, bresp held stable until bready. On bvalid&&bready go to IDLE; bvalid=0 and awready=1 the next cycle.
- Back-to-back minimum per burst: 1 AW cycle + (len+1) beats + 1 B cycle.
- EXOKAY is never generated.

Optional Feature:
- Macro AXI4_WR_4KB_BOUNDARY_CHECK_EN.
- Defined: an INCR burst whose first and last beat addresses differ in bits [ADDRESS_WIDTH-1:12] returns SLVERR with no memory writes; all beats are still consumed.
- Not defined: no 4 KB check; addresses continue linearly across the boundary.

Test Plan:
- INCR, awaddr=0x100, awlen=3, awsize=3, wstrb=0xFF -> mem_addr 0x100/0x108/0x110/0x118, then bresp=OKAY, bid=awid.
- WRAP, awaddr=0x1C, awlen=3, awsize=2 -> mem_addr 0x1C, 0x10, 0x14, 0x18; bresp=OKAY.
- FIXED, awaddr=0x204, awlen=2, awsize=2 -> three writes at 0x204 with per-beat wstrb passed through; bresp=OKAY.
- awaddr=0x3000 (above MAX_ADDRESS), awlen=1 -> 2 beats accepted, no mem_we, bresp=DECERR; awburst=3 -> SLVERR, no mem_we.
- awlen=3 with wlast asserted on beat 1 -> 4 writes issued, bresp=SLVERR; bready held low 5 cycles -> bvalid/bresp stable, awready=0 throughout.
- Reset asserted on beat 2 of a 4-beat INCR -> outputs return to reset values immediately; the next burst awid=5, awaddr=0x40, awlen=0 completes OKAY with bid=5. With the macro defined, INCR awaddr=0xFF8, awlen=1, awsize=3 -> SLVERR, no writes.
